// File: rtl/addsub_seq.sv
// addsub_seq: a multi-cycle adder/subtractor that processes a WIDTH-bit operand pair
// one DIGIT-bit slice per clock, LSB slice first.
// A single ripple slice is used, and the carry between slices is held in a register.
// Subtraction is computed as A + ~B + 1: the B slice is inverted and the initial carry is set to mode.
// WIDTH must be a positive multiple of DIGIT.
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SUM,
    output logic             Cout,
    output logic             OVF,
    output logic             ZERO
);

    localparam int NS = WIDTH / DIGIT;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_nxt;
    logic             mode_reg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] a_sl, b_sl;
    logic [DIGIT:0]   slice_sum;
    logic             c_msb;
    logic             last;
    logic             accept;

    assign last   = (cnt == CW'(NS - 1));
    // A start request is honoured in both IDLE and DONE, so back-to-back operations lose no cycle.
    assign accept = start && (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // Datapath for one slice: select the current slice of each latched operand and ripple-add them.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        a_sl      = a_reg[int'(cnt)*DIGIT +: DIGIT];
        b_sl      = b_reg[int'(cnt)*DIGIT +: DIGIT] ^ {DIGIT{mode_reg}};
        slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry};
        // Carry into the top bit of the slice, recovered from the sum bit: s = a ^ b ^ cin.
        c_msb     = slice_sum[DIGIT-1] ^ a_sl[DIGIT-1] ^ b_sl[DIGIT-1];
        res_nxt   = res_reg;
        res_nxt[int'(cnt)*DIGIT +: DIGIT] = slice_sum[DIGIT-1:0];
    end

    // Next-state logic: IDLE -> RUN on start; RUN for NS slices; DONE for one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Operand latch, slice iteration, and update of the result/flags at the final slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            mode_reg <= 1'b0;
            res_reg  <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            SUM      <= '0;
            Cout     <= 1'b0;
            OVF      <= 1'b0;
            ZERO     <= 1'b0;
        end else if (accept) begin
            a_reg    <= A;
            b_reg    <= B;
            mode_reg <= mode;
            carry    <= mode;
            cnt      <= '0;
        end else if (state == RUN) begin
            res_reg <= res_nxt;
            carry   <= slice_sum[DIGIT];
            cnt     <= cnt + CW'(1);
            if (last) begin
                SUM  <= res_nxt;
                Cout <= slice_sum[DIGIT];
                OVF  <= c_msb ^ slice_sum[DIGIT];
                ZERO <= (res_nxt == '0);
            end
        end
    end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair one DIGIT-bit slice per clock, LSB slice first, through a single ripple-carry slice with a registered inter-slice carry. Add and subtract are selected per operation: subtract is A + ~B + 1. It generalises the 4-bit ripple-carry add/subtract datapath to arbitrary width with a start/done handshake and status flags. It sits in the COA datapath wherever a narrow adder must serve a wide operand over several cycles.

## Interface

- WIDTH, 16, operand/result width in bits; must be a positive multiple of DIGIT
- DIGIT, 4, slice width processed per clock
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when busy=0
- mode  input  1  0 = add, 1 = subtract; sampled with start
- A  input  WIDTH  operand A; sampled with start
- B  input  WIDTH  operand B; sampled with start
- busy  output  1  high while slices are being processed
- done  output  1  one-cycle pulse; result outputs updated at the same edge
- SUM  output  WIDTH  result (A+B or A-B, modulo 2^WIDTH)
- Cout  output  1  carry out of MSB; for subtract, 1 = no borrow (A >= B unsigned)
- OVF  output  1  signed overflow: carry into MSB XOR carry out of MSB
- ZERO  output  1  SUM == 0

## Operation

- NS = WIDTH/DIGIT slices; slice counter is clog2(NS) bits wide, with a minimum of 1 bit.
- FSM states:
  - IDLE
    - start=1 latches A, B and mode into internal registers.
    - Carry register is loaded with mode.
    - Slice counter is cleared to 0; next state is RUN.
  - RUN
    - Each edge computes {c, s} = A_slice[i] + (B_slice[i] XOR {DIGIT{mode}}) + carry.
    - s is stored into bits [i*DIGIT +: DIGIT] of the internal result register; the carry register takes c.
    - The counter increments each edge; after slice NS-1, next state is DONE.
  - DONE
    - done=1 and busy=0.
    - start=1 here is accepted exactly as in IDLE (next state RUN), so back-to-back operations lose no cycle.
    - Otherwise next state is IDLE.
- On the edge that processes slice NS-1, all of the following are loaded together:
  - SUM from the full result
  - Cout from the final carry
  - OVF from (carry into MSB) XOR (final carry), where carry into MSB is taken from bit DIGIT-1 of the last slice's internal ripple
  - ZERO from (full result == 0)
- SUM, Cout, OVF and ZERO hold their previous values throughout RUN and change only at completion.
- Inputs A, B and mode may change freely while busy=1; only the latched copies are used.
- start while busy=1 is ignored and is not queued.
- Reset (asynchronous, any state, including mid-RUN):
  - FSM goes to IDLE; counter and carry are cleared.
  - busy=0, done=0, SUM=0, Cout=0, OVF=0, ZERO=0.
  - Any partial result is discarded.

## Timing

- Start accepted at edge k.
- busy=1 from after edge k until edge k+NS.
- done=1 and new results are visible after edge k+NS, for exactly one cycle.
- Latency from start edge to results is NS cycles: WIDTH=16, DIGIT=4 gives 4 cycles.
- With start held high continuously, throughput is one result per NS+1 cycles.
- WIDTH=DIGIT (NS=1): one RUN cycle; done appears after edge k+1.
- rst_n deassertion is synchronised by the environment; the block must not assume any alignment of rst_n relative to clk on assertion.

## Test plan

- Add, WIDTH=16: A=0x1234, B=0x4321, mode=0
  - Response: SUM=0x5555, Cout=0, OVF=0, ZERO=0.
  - done exactly 4 cycles after the start edge; busy high for those 4 cycles.
- Subtract:
  - 0x0003-0x0002 gives SUM=0x0001, Cout=1.
  - 0x0002-0x0003 gives SUM=0xFFFF, Cout=0, OVF=0.
  - 0x000F-0x0001 gives SUM=0x000E, Cout=1.
  - 0x000A-0x0005 gives SUM=0x0005, Cout=1.
- Flags:
  - 0x7FFF+0x0001 gives SUM=0x8000, OVF=1, Cout=0.
  - 0x8000-0x0001 gives SUM=0x7FFF, OVF=1, Cout=1.
  - 0x1234-0x1234 gives SUM=0x0000, ZERO=1, Cout=1.
  - 0xFFFF+0x0001 gives SUM=0, Cout=1, ZERO=1, OVF=0.
- Handshake:
  - A second start pulse (A=0x0001, B=0x0001) mid-RUN is ignored; the first result is unchanged.
  - start held high continuously yields done every 5 cycles with correct alternating operands.
- Reset: rst_n pulsed low during slice 2 of an operation
  - All outputs 0 and busy=0 immediately, without waiting for a clock edge.
  - The next start completes normally with a correct result.
- Parameter sweep: WIDTH=4 gives 15-1=14 with done after 1 cycle; WIDTH=32 gives 0xFFFFFFFF+1=0 with Cout=1 after 8 cycles.
